// File: rtl/ro_count_reader.sv
// Captures the final ring-oscillator count of each gate window and presents it both as a
// held parallel word (valid/ack) and as an MSB-first framed serial stream.
module ro_count_reader #(
    parameter int N    = 8,
    parameter int SDIV = 4
) (
    input  logic         osc_clk,
    input  logic         reset,
    input  logic         gate,
    input  logic         en,
    input  logic [N-1:0] count,
    input  logic         rd_ack,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         overrun,
    output logic         sdata,
    output logic         sframe
);
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] BLOAD = BW'(N - 1);
    localparam logic [7:0]    DLOAD = 8'(SDIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic          g1, g2, g3;
    logic [N-1:0]  c1, c2;
    logic          cap;

    state_t        state, state_nxt;
    logic [N-1:0]  shreg, shreg_nxt;
    logic [N-1:0]  shifted;
    logic [N-1:0]  pend_val, pend_val_nxt;
    logic          pending, pending_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic [7:0]    dcnt, dcnt_nxt;
    logic          sdata_nxt, sframe_nxt;
    logic          load_en;
    logic [N-1:0]  load_val;

    // c1 samples count on the same edge g1 samples gate, so it holds the pre-clear value
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            g1 <= 1'b0;
            g2 <= 1'b0;
            g3 <= 1'b0;
            c1 <= '0;
            c2 <= '0;
        end else begin
            g1 <= gate;
            g2 <= g1;
            g3 <= g2;
            c1 <= count;
            c2 <= c1;
        end
    end

    assign cap = g2 & ~g3 & en;

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (cap) begin
            data_out   <= c2;
            data_valid <= 1'b1;
            if (data_valid && !rd_ack) begin
                overrun <= 1'b1;
            end
        end else if (rd_ack && data_valid) begin
            data_valid <= 1'b0;
        end
    end

    assign shifted = shreg << 1;

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        pend_val_nxt = pend_val;
        pending_nxt  = pending;
        bcnt_nxt     = bcnt;
        dcnt_nxt     = dcnt;
        sdata_nxt    = sdata;
        sframe_nxt   = sframe;
        load_en      = 1'b0;
        load_val     = c2;

        case (state)
            IDLE: begin
                if (cap) begin
                    load_en  = 1'b1;
                    load_val = c2;
                end
            end
            SHIFT: begin
                // The running frame is never touched; a capture only refreshes the single pending slot
                if (cap) begin
                    pend_val_nxt = c2;
                    pending_nxt  = 1'b1;
                end
                if (dcnt != '0) begin
                    dcnt_nxt = dcnt - 8'd1;
                end else if (bcnt != '0) begin
                    shreg_nxt = shifted;
                    sdata_nxt = shifted[N-1];
                    bcnt_nxt  = bcnt - 1'b1;
                    dcnt_nxt  = DLOAD;
                end else if (pending) begin
                    load_en  = 1'b1;
                    load_val = pend_val;
                    if (!cap) begin
                        pending_nxt = 1'b0;
                    end
                end else if (cap) begin
                    // Capture landing on the last cycle of a frame starts the next frame directly
                    load_en     = 1'b1;
                    load_val    = c2;
                    pending_nxt = 1'b0;
                end else begin
                    state_nxt  = IDLE;
                    sframe_nxt = 1'b0;
                    sdata_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load_en) begin
            state_nxt  = SHIFT;
            shreg_nxt  = load_val;
            bcnt_nxt   = BLOAD;
            dcnt_nxt   = DLOAD;
            sframe_nxt = 1'b1;
            sdata_nxt  = load_val[N-1];
        end
    end

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            pend_val <= '0;
            pending  <= 1'b0;
            bcnt     <= '0;
            dcnt     <= '0;
            sdata    <= 1'b0;
            sframe   <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            pend_val <= pend_val_nxt;
            pending  <= pending_nxt;
            bcnt     <= bcnt_nxt;
            dcnt     <= dcnt_nxt;
            sdata    <= sdata_nxt;
            sframe   <= sframe_nxt;
        end
    end

endmodule

// File: tb/tb_ro_count_reader.sv
// Directed bench for ro_count_reader: parallel captures are checked three edges after each
// gate rise, serial frames are decoded and compared against a queue of expected words.
module tb_ro_count_reader;
    localparam int N    = 8;
    localparam int SDIV = 4;

    logic         osc_clk = 1'b0;
    logic         reset;
    logic         gate;
    logic         en;
    logic [N-1:0] count;
    logic         rd_ack;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         overrun;
    logic         sdata;
    logic         sframe;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] par_q[$];
    logic [N-1:0] ser_q[$];

    int           ser_cyc  = 0;
    int           run_len  = 0;
    int           last_run = 0;
    logic [N-1:0] ser_cur  = '0;

    ro_count_reader #(.N(N), .SDIV(SDIV)) dut (
        .osc_clk   (osc_clk),
        .reset     (reset),
        .gate      (gate),
        .en        (en),
        .count     (count),
        .rd_ack    (rd_ack),
        .data_out  (data_out),
        .data_valid(data_valid),
        .overrun   (overrun),
        .sdata     (sdata),
        .sframe    (sframe)
    );

    always #5 osc_clk = ~osc_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial decoder: every cycle of a frame is compared against the expected word's bit
    always @(negedge osc_clk) begin
        if (reset) begin
            ser_cyc = 0;
            run_len = 0;
        end else if (sframe) begin
            if (ser_cyc == 0) begin
                check("ser_frame_expected", 32'(ser_q.size() != 0), 32'd1);
                if (ser_q.size() != 0) ser_cur = ser_q.pop_front();
            end
            check("sdata_bit", 32'(sdata), 32'(ser_cur[N-1-ser_cyc/SDIV]));
            ser_cyc++;
            if (ser_cyc == N*SDIV) ser_cyc = 0;
            run_len++;
        end else begin
            if (run_len != 0) begin
                check("frame_whole", 32'(ser_cyc), 32'd0);
                check("sdata_idle", 32'(sdata), 32'd0);
                last_run = run_len;
            end
            run_len = 0;
            ser_cyc = 0;
        end
    end

    task automatic capture(input logic [N-1:0] val, input logic en_v, input logic push_ser,
                           input logic ack_at_cap, input int hold);
        logic [N-1:0] exp;
        @(negedge osc_clk); count = val; en = en_v;
        @(negedge osc_clk);
        @(negedge osc_clk); gate = 1'b1;
        if (en_v) begin
            par_q.push_back(val);
            if (push_ser) ser_q.push_back(val);
        end
        @(negedge osc_clk); count = '0;
        @(negedge osc_clk); rd_ack = ack_at_cap;
        @(negedge osc_clk); rd_ack = 1'b0;
        if (en_v) begin
            exp = par_q.pop_front();
            check("cap_valid", 32'(data_valid), 32'd1);
            check("cap_data", 32'(data_out), 32'(exp));
        end
        for (int i = 3; i < hold; i++) @(negedge osc_clk);
        gate = 1'b0;
        @(negedge osc_clk); en = 1'b1;
    endtask

    task automatic ack(input string tag);
        @(negedge osc_clk); rd_ack = 1'b1;
        @(negedge osc_clk); rd_ack = 1'b0;
        check(tag, 32'(data_valid), 32'd0);
    endtask

    task automatic wait_frame_end(input int maxc, input int exp_len);
        int n = 0;
        do begin
            @(negedge osc_clk);
            n++;
        end while (sframe !== 1'b0 && n < maxc);
        check("frame_end_timeout", 32'(sframe), 32'd0);
        @(negedge osc_clk);
        check("frame_length", 32'(last_run), 32'(exp_len));
    endtask

    initial begin
        int n;
        int hi;
        reset = 1'b1; gate = 1'b0; en = 1'b1; rd_ack = 1'b0; count = '0;
        repeat (3) @(negedge osc_clk);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_sdata", 32'(sdata), 32'd0);
        check("rst_sframe", 32'(sframe), 32'd0);
        reset = 1'b0;

        // Ramp with gate low, raise gate on 0x9F; counter clears on the next edge
        for (int i = 0; i <= 'h9F; i++) begin
            @(negedge osc_clk); count = 8'(i);
        end
        gate = 1'b1;
        ser_q.push_back(8'h9F);
        @(negedge osc_clk); count = '0;
        check("lat_edge1", 32'(data_valid), 32'd0);
        @(negedge osc_clk);
        check("lat_edge2", 32'(data_valid), 32'd0);
        @(negedge osc_clk);
        check("lat_edge3_valid", 32'(data_valid), 32'd1);
        check("lat_edge3_data", 32'(data_out), 32'h9F);
        check("lat_overrun", 32'(overrun), 32'd0);
        gate = 1'b0;
        ack("ack_9f");
        wait_frame_end(200, 32);

        capture(8'hA5, 1'b1, 1'b1, 1'b0, 3);
        check("a5_overrun", 32'(overrun), 32'd0);
        wait_frame_end(200, 32);

        // rd_ack on the capture edge: new sample wins, no overrun
        capture(8'h5A, 1'b1, 1'b1, 1'b1, 3);
        check("ack_cap_overrun", 32'(overrun), 32'd0);
        ack("ack_5a");
        wait_frame_end(200, 32);

        capture(8'h12, 1'b1, 1'b1, 1'b0, 3);
        capture(8'h34, 1'b1, 1'b1, 1'b0, 3);
        check("ovr_set", 32'(overrun), 32'd1);
        ack("ack_34");
        check("ovr_sticky", 32'(overrun), 32'd1);
        ack("ack_idle_ignored");
        wait_frame_end(200, 64);

        capture(8'h11, 1'b1, 1'b1, 1'b0, 3);
        capture(8'h22, 1'b1, 1'b0, 1'b0, 3);
        capture(8'h33, 1'b1, 1'b1, 1'b0, 3);
        wait_frame_end(200, 64);

        ack("ack_33");
        capture(8'h40, 1'b0, 1'b0, 1'b0, 3);
        check("en0_valid", 32'(data_valid), 32'd0);
        check("en0_sframe", 32'(sframe), 32'd0);
        capture(8'h6B, 1'b1, 1'b1, 1'b0, 50);
        ack("ack_held_gate");
        repeat (3) @(negedge osc_clk);
        check("held_gate_single", 32'(data_valid), 32'd0);
        wait_frame_end(200, 32);

        // Reset in the middle of a frame with a pending word queued behind it
        capture(8'h77, 1'b1, 1'b1, 1'b0, 3);
        capture(8'h78, 1'b1, 1'b1, 1'b0, 3);
        check("pre_rst_overrun", 32'(overrun), 32'd1);
        n = 0;
        while (ser_cyc < 3*SDIV + 1 && n < 100) begin
            @(negedge osc_clk);
            n++;
        end
        check("bit3_reached", 32'(ser_cyc >= 3*SDIV + 1), 32'd1);
        reset = 1'b1;
        ser_q.delete();
        @(negedge osc_clk);
        check("mid_rst_data_out", 32'(data_out), 32'd0);
        check("mid_rst_valid", 32'(data_valid), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_sdata", 32'(sdata), 32'd0);
        check("mid_rst_sframe", 32'(sframe), 32'd0);
        @(negedge osc_clk); reset = 1'b0;
        hi = 0;
        repeat (40) begin
            @(negedge osc_clk);
            if (sframe) hi++;
        end
        check("no_frame_after_rst", 32'(hi), 32'd0);

        capture(8'h3C, 1'b1, 1'b1, 1'b0, 3);
        check("post_rst_overrun", 32'(overrun), 32'd0);
        wait_frame_end(200, 32);
        ack("ack_3c");

        capture(8'hFF, 1'b1, 1'b1, 1'b0, 3);
        wait_frame_end(200, 32);

        check("par_q_empty", 32'(par_q.size()), 32'd0);
        check("ser_q_empty", 32'(ser_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
